// File: rtl/mul_stream_adapter.sv
// mul_stream_adapter
// Valid/ready front end and result buffer for a sequential multiplier core.
// An accepted operand pair is latched and launched with a one-cycle start
// pulse; the core's done pulse pushes the product into a small FIFO that
// drains on the output stream. Only one operation is ever in flight, and a
// FIFO slot is reserved at accept time so the push can never overflow.
module mul_stream_adapter #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 terr_q, terr_d;

    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;

    logic                 can_accept_s;
    logic                 push_s;
    logic                 pop_s;

    // Space is judged on the registered count only; a pop this cycle does not help.
    assign can_accept_s = (count_q < CW'(DEPTH));
    assign pop_s        = (count_q != CW'(0)) && out_ready;

    // Next-state logic: accept in IDLE, single issue cycle, then wait for done or timeout.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        terr_d  = terr_q;
        push_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && can_accept_s) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_d = TW'(0);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done has priority over the terminal timer count
                if (mul_done) begin
                    push_s  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, wait timer, latched operands, sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= TW'(0);
            a_q     <= WIDTH'(0);
            b_q     <= WIDTH'(0);
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            terr_q  <= terr_d;
        end
    end

    // Result FIFO: registered push/pop, pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (2*WIDTH)'(0);
            end
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= mul_product;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // in_ready is held low while reset is applied so nothing looks acceptable then.
    assign in_ready    = !reset && (state_q == ST_IDLE) && can_accept_s;
    assign out_valid   = (count_q != CW'(0));
    assign out_product = mem_q[rd_ptr_q];
    assign mul_start   = (state_q == ST_ISSUE);
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mul_stream_adapter.sv
// Bench for mul_stream_adapter: transaction-level reference model (operation
// age counter plus a product queue) checked against the DUT every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_mul_stream_adapter;

    localparam int W  = 16;
    localparam int D  = 2;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_done = 1'b0;
    logic [2*W-1:0] mul_product = '0;
    logic          busy;
    logic          timeout_err;

    mul_stream_adapter #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: m_age = cycles since the op was accepted (-1 = none).
    // Age 1 is the start cycle, ages >= 2 are waiting (wait index = age-2).
    int            m_age = -1;
    logic [31:0]   m_q[$];
    logic [15:0]   m_a = '0;
    logic [15:0]   m_b = '0;
    bit            m_terr = 1'b0;
    int            core_lat = 16;
    bit            core_never = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input bit rst_now);
        cmp("in_ready",  32'(in_ready),  32'(!rst_now && m_age < 0 && m_q.size() < D));
        cmp("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) cmp("out_product", out_product, m_q[0]);
        cmp("mul_start", 32'(mul_start), 32'(m_age == 1));
        cmp("busy",      32'(busy),      32'(m_age >= 1));
        cmp("mul_a",     32'(mul_a),     32'(m_a));
        cmp("mul_b",     32'(mul_b),     32'(m_b));
        cmp("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    // One clock: drive at negedge, advance the model, check #1 after posedge.
    task automatic step(input bit rst, input bit iv, input logic [15:0] a, input logic [15:0] b,
                        input bit ordy, input bit done, input logic [31:0] prod);
        bit acc;
        bit pop;
        @(negedge clk);
        reset = rst; in_valid = iv; in_a = a; in_b = b;
        out_ready = ordy; mul_done = done; mul_product = prod;
        if (rst) begin
            m_age = -1; m_q.delete(); m_a = '0; m_b = '0; m_terr = 1'b0;
        end else begin
            acc = iv && (m_age < 0) && (m_q.size() < D);
            pop = (m_q.size() > 0) && ordy;
            if (pop) void'(m_q.pop_front());
            if (m_age >= 2 && done) begin
                m_q.push_back(prod);
                m_age = -1;
            end else if (m_age == TO + 1) begin
                m_terr = 1'b1;
                m_age = -1;
            end else if (m_age >= 1) begin
                m_age++;
            end
            if (acc) begin
                m_age = 1; m_a = a; m_b = b;
            end
        end
        @(posedge clk);
        #1;
        check(rst);
    endtask

    // One clock with the behavioural core answering after core_lat wait cycles.
    task automatic cyc(input bit iv, input logic [15:0] a, input logic [15:0] b, input bit ordy,
                       input bit stray, input logic [31:0] sprod);
        bit done;
        logic [31:0] prod;
        done = 1'b0;
        prod = 32'h0;
        if (m_age >= 2 && !core_never && (m_age - 2) == core_lat) begin
            done = 1'b1;
            prod = 32'(m_a) * 32'(m_b);
        end else if (stray && m_age < 2) begin
            done = 1'b1;
            prod = sprod;
        end
        step(1'b0, iv, a, b, ordy, done, prod);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, ordy, 1'b0, 32'h0);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        bit got;
        got = 1'b0;
        cyc(1'b1, a, b, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 200 && !got; i++) begin
            if (out_valid) begin
                cmp(name, out_product, exp);
                got = 1'b1;
            end else begin
                cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 32'h0);
            end
        end
        if (!got) cmp({name, "_never_valid"}, 32'd0, 32'd1);
        idle(2, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int first;
        int n;
        bit sent;
        logic [31:0] got[$];
        logic [31:0] exp3[3];

        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0);
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        cmp("rst_out_product", out_product, 32'h0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 32'h0);
        cmp("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 1: 3*5, start on cycle 1, product valid exactly one cycle at done+1
        core_lat = 16;
        cyc(1'b1, 16'd3, 16'd5, 1'b1, 1'b0, 32'h0);
        cmp("t1_start", 32'(mul_start), 32'd1);
        cmp("t1_mul_a", 32'(mul_a), 32'd3);
        cmp("t1_mul_b", 32'(mul_b), 32'd5);
        nv = 0;
        first = 0;
        for (int j = 1; j <= 40; j++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 32'h0);
            if (j == 1) cmp("t1_start_single", 32'(mul_start), 32'd0);
            if (out_valid) begin
                nv++;
                if (first == 0) first = j + 1;
                cmp("t1_product", out_product, 32'h0000000F);
            end
        end
        cmp("t1_valid_cycles", 32'(nv), 32'd1);
        cmp("t1_latency", 32'(first), 32'd19);

        // 2: extremes
        core_lat = 16;
        run_op("t2_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_op("t2_zero", 16'h0000, 16'h1234, 32'h00000000);

        // 3: backpressure fills FIFO, third op refused until drained
        core_lat = 3;
        cyc(1'b1, 16'd2, 16'd3, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 30 && m_q.size() < 1; i++) idle(1, 1'b0);
        cyc(1'b1, 16'd4, 16'd5, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 30 && m_q.size() < 2; i++) idle(1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'd6, 16'd7, 1'b0, 1'b0, 32'h0);
        cmp("t3_in_ready_low", 32'(in_ready), 32'd0);
        cmp("t3_not_accepted", 32'(busy), 32'd0);
        sent = 1'b0;
        for (int i = 0; i < 100 && got.size() < 3; i++) begin
            if (out_valid) got.push_back(out_product);
            cyc(!sent, 16'd6, 16'd7, 1'b1, 1'b0, 32'h0);
            if (m_age == 1) sent = 1'b1;
        end
        exp3[0] = 32'd6; exp3[1] = 32'd20; exp3[2] = 32'd42;
        cmp("t3_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++) cmp("t3_order", got[i], exp3[i]);
        idle(2, 1'b1);

        // 4: core never answers -> timeout after 64 wait cycles
        core_never = 1'b1;
        cyc(1'b1, 16'd3, 16'd3, 1'b1, 1'b0, 32'h0);
        n = 0;
        for (int i = 0; i < 100 && !timeout_err; i++) begin
            idle(1, 1'b1);
            n++;
        end
        cmp("t4_steps_to_timeout", 32'(n), 32'd65);
        cmp("t4_timeout_err", 32'(timeout_err), 32'd1);
        cmp("t4_out_valid", 32'(out_valid), 32'd0);
        cmp("t4_in_ready", 32'(in_ready), 32'd1);
        core_never = 1'b0;
        core_lat = 5;
        run_op("t4_after", 16'd2, 16'd2, 32'd4);
        cmp("t4_sticky", 32'(timeout_err), 32'd1);

        // 5: reset mid-wait with a stray done, then another stray done in idle
        core_lat = 10;
        cyc(1'b1, 16'd7, 16'd9, 1'b1, 1'b0, 32'h0);
        idle(4, 1'b1);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 32'd63);
        cmp("t5_out_valid", 32'(out_valid), 32'd0);
        cmp("t5_mul_a", 32'(mul_a), 32'd0);
        cmp("t5_mul_b", 32'(mul_b), 32'd0);
        cmp("t5_busy", 32'(busy), 32'd0);
        cmp("t5_terr", 32'(timeout_err), 32'd0);
        cmp("t5_in_ready", 32'(in_ready), 32'd0);
        cmp("t5_out_product", out_product, 32'h0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 32'd63);
        idle(20, 1'b1);
        cmp("t5_no_write", 32'(out_valid), 32'd0);

        // 6: done pulse in idle is ignored
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 32'h0000DEAD);
        idle(3, 1'b1);
        cmp("t6_ignored", 32'(out_valid), 32'd0);

        // done on the same cycle as the terminal timer count wins
        core_lat = TO - 1;
        run_op("t7_done_wins", 16'd5, 16'd6, 32'd30);
        cmp("t7_no_timeout", 32'(timeout_err), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_age < 0) begin
                core_never = ($urandom_range(0, 19) == 0);
                core_lat = $urandom_range(0, 20);
            end
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                     1'($urandom), $urandom);
            end else begin
                cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
